// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding and
// word-packing constants.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        GO      = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int ADDR_STEP      = 4;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Shift-in register that packs a byte stream MSB first and flags the cycle
// in which the last byte of a word is accepted.
module program_loader_byte_packer
    import program_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             accept,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] word_next,
    output logic             word_full
);

    logic [WIDTH-1:0]      word;
    logic [BYTE_IDX_W-1:0] idx;

    // Earlier bytes migrate toward the MSBs as later bytes arrive.
    assign word_next = {word[WIDTH-9:0], byte_in};
    assign word_full = accept && (idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx  <= '0;
        end else if (accept) begin
            idx  <= idx + 1'b1;
            word <= word_next;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: packs a byte stream into words, writes them to consecutive
// CPU RAM addresses through the prepopulation port, then pulses go_contr.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int AWIDTH    = 6,
    parameter int CWIDTH    = 16,
    parameter int ADDR_STEP = program_loader_pkg::ADDR_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [WIDTH-1:0]  base_addr,
    input  logic [CWIDTH-1:0] word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [WIDTH-1:0]  addrIn,
    output logic [WIDTH-1:0]  dataTemp,
    output logic              wrIn,
    output logic              go_contr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned MAX_WORDS = 2 ** AWIDTH;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  addr_reg;
    logic [CWIDTH-1:0] remaining;
    logic              accept;
    logic              word_full;
    logic [WIDTH-1:0]  word_next;
    logic              req_seen;
    logic              req_oversize;
    logic              req_launch;

    // Requests are only honoured while not busy; everything else is dropped silently.
    assign req_seen     = load_start && ((state == IDLE) || (state == DONE));
    assign req_oversize = 32'(word_count) > MAX_WORDS;
    assign req_launch   = req_seen && !req_oversize;
    assign accept       = byte_valid && byte_ready;

    program_loader_byte_packer #(
        .WIDTH (WIDTH)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (req_launch),
        .accept    (accept),
        .byte_in   (byte_in),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        go_contr   = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (req_launch) begin
                    state_next = (word_count == '0) ? GO : COLLECT;
                end
            end
            COLLECT: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (word_full) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy       = 1'b1;
                state_next = (remaining == CWIDTH'(1)) ? GO : COLLECT;
            end
            GO: begin
                busy       = 1'b1;
                go_contr   = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The RAM port is fully registered: address and data are captured on the
    // same edge that raises wrIn, so all three are stable across WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg  <= '0;
            remaining <= '0;
            addrIn    <= '0;
            dataTemp  <= '0;
            wrIn      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wrIn <= (state_next == WRITE);
            err  <= req_seen && req_oversize;
            if (req_launch) begin
                addr_reg  <= base_addr;
                remaining <= word_count;
            end
            if (state == WRITE) begin
                addr_reg  <= addr_reg + WIDTH'(ADDR_STEP);
                remaining <= remaining - 1'b1;
            end
            if (state_next == WRITE) begin
                addrIn   <= addr_reg;
                dataTemp <= word_next;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: stimulus pushes expected RAM
// writes and start pulses, a negedge monitor pops and compares them.
module tb_program_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] addrIn;
    logic [31:0] dataTemp;
    logic        wrIn;
    logic        go_contr;
    logic        busy;
    logic        done;
    logic        err;

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .addrIn     (addrIn),
        .dataTemp   (dataTemp),
        .wrIn       (wrIn),
        .go_contr   (go_contr),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wr_t        exp_wr[$];
    logic [7:0] stim[$];
    int exp_go = 0, exp_err = 0;
    int checks = 0, errors = 0;
    int wr_seen = 0, go_seen = 0;
    int last_wr_cyc = -1, last_go_cyc = -1, last_err_cyc = -1;
    int t0 = 0;
    logic prev_wr = 1'b0;
    wr_t  mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every DUT event is matched against what the stimulus predicted.
    always @(negedge clk) begin
        if (wrIn === 1'b1) begin
            wr_seen++;
            last_wr_cyc = cyc;
            check("wr_back_to_back", prev_wr, 0);
            check("wr_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
                mon_e = exp_wr.pop_front();
                check("wr_addr", addrIn, mon_e.addr);
                check("wr_data", dataTemp, mon_e.data);
            end
        end
        prev_wr = (wrIn === 1'b1);
        if (go_contr === 1'b1) begin
            go_seen++;
            last_go_cyc = cyc;
            check("go_expected", exp_go > 0, 1);
            if (exp_go > 0) exp_go--;
        end
        if (err === 1'b1) begin
            last_err_cyc = cyc;
            check("err_expected", exp_err > 0, 1);
            if (exp_err > 0) exp_err--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a load of n words is n writes of MSB-first packed bytes
    // at base + 4*i (32-bit wrap) followed by one start pulse; n > 64 is an error.
    task automatic request(input logic [31:0] base, input int n, input bit keep_stim);
        if (!keep_stim) stim.delete();
        if (n > 64) begin
            exp_err++;
        end else begin
            if (!keep_stim)
                for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
            for (int w = 0; w < n; w++) begin
                wr_t e;
                e.addr = base + 32'(4 * w);
                e.data = {stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]};
                exp_wr.push_back(e);
            end
            exp_go++;
        end
        load_start = 1'b1;
        base_addr  = base;
        word_count = 16'(n);
        t0 = cyc;
        tick();
        load_start = 1'b0;
    endtask

    // Feeds stim; poke_at pulses a stray load_start alongside that byte index.
    task automatic stream(input int stall_pct, input int poke_at, input int limit);
        int i = 0;
        int k = 0;
        int n = (limit < 0) ? stim.size() : limit;
        bit poked = 0;
        while (i < n && k < 40 * n + 50) begin
            byte_valid = ($urandom_range(99) >= stall_pct);
            byte_in    = byte_valid ? stim[i] : 8'($urandom);
            if (i == poke_at && !poked) begin
                poked      = 1;
                load_start = 1'b1;
                base_addr  = 32'h0000_ABC0;
                word_count = 16'(($urandom_range(1) == 0) ? 70 : 7);
            end
            @(negedge clk);
            if (byte_valid && byte_ready) i++;
            tick();
            load_start = 1'b0;
            k++;
        end
        byte_valid = 1'b0;
        check("stream_progress", i, n);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(name, done, 1);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("go_drained", exp_go, 0);
        tick();
    endtask

    task automatic check_quiet(input string name);
        @(negedge clk);
        check({name, "_ctrl"}, {wrIn, go_contr, busy, done, err, byte_ready}, 6'b0);
        check({name, "_addr"}, addrIn, 0);
        check({name, "_data"}, dataTemp, 0);
    endtask

    initial begin
        int wr0, go0;
        repeat (3) tick();
        reset = 1'b0;
        check_quiet("reset_state");
        tick();

        // Bytes offered in IDLE must be refused and leave the loader idle.
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_byte_ready", byte_ready, 0);
            check("idle_busy", busy, 0);
            tick();
        end
        byte_valid = 1'b0;

        // Oversize request from IDLE.
        request(32'h0, 65, 0);
        tick();
        @(negedge clk);
        check("oversize_err_cycle", last_err_cyc, t0 + 1);
        check("oversize_stays_idle", {busy, done, byte_ready}, 3'b000);
        check("oversize_err_drained", exp_err, 0);
        tick();

        // Single word with fixed bytes and exact latency.
        stim.delete();
        stim.push_back(8'hDE); stim.push_back(8'hAD);
        stim.push_back(8'hBE); stim.push_back(8'hEF);
        wr0 = wr_seen;
        request(32'h0, 1, 1);
        stream(0, -1, -1);
        wait_done("single_done");
        check("single_wr_cycle", last_wr_cyc, t0 + 5);
        check("single_go_cycle", last_go_cyc, t0 + 6);
        check("single_wr_count", wr_seen - wr0, 1);

        // Oversize request from DONE keeps done asserted.
        request(32'h40, 65, 0);
        tick();
        @(negedge clk);
        check("done_oversize_err_cycle", last_err_cyc, t0 + 1);
        check("done_held", done, 1);
        tick();

        // Zero-length load starts the CPU immediately.
        wr0 = wr_seen;
        request(32'h80, 0, 0);
        wait_done("zero_done");
        check("zero_go_cycle", last_go_cyc, t0 + 1);
        check("zero_no_wr", wr_seen - wr0, 0);

        // Multi-word with a stalled stream and a stray load_start mid-collect.
        wr0 = wr_seen;
        go0 = go_seen;
        request(32'h10, 3, 0);
        stream(50, 5, -1);
        wait_done("multi_done");
        check("multi_wr_count", wr_seen - wr0, 3);
        check("multi_go_count", go_seen - go0, 1);

        // Address wrap past the top of the 32-bit space.
        request(32'hFFFF_FFFC, 2, 0);
        stream(30, -1, -1);
        wait_done("wrap_done");

        // Largest legal image.
        wr0 = wr_seen;
        request(32'($urandom) & 32'hFFFF_FFFC, 64, 0);
        stream(20, -1, -1);
        wait_done("max_done");
        check("max_wr_count", wr_seen - wr0, 64);

        // Reset after six bytes: the first word is written, the second dropped.
        go0 = go_seen;
        request(32'h200, 2, 0);
        stream(0, -1, 6);
        reset = 1'b1;
        exp_wr.delete();
        exp_go = 0;
        tick();
        reset = 1'b0;
        check_quiet("midreset");
        repeat (8) tick();
        check("midreset_no_go", go_seen - go0, 0);

        // Fresh loads afterwards must pack from byte index 0.
        for (int r = 0; r < 4; r++) begin
            request(32'($urandom), $urandom_range(4, 1), 0);
            stream($urandom_range(60), -1, -1);
            wait_done("random_done");
        end

        check("final_err_drained", exp_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
